// File: rtl/cla_pipe_adder_if.sv
// Operand/result bundle for cla_pipe_adder: valid/ready upstream with operands,
// valid/ready downstream with the result. The adder uses the slave view.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices of 4-bit CLA groups with
// registered slice carries. Define CLA_PIPE_SAT_EN for signed saturation on overflow.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int GROUP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave bus
);
    localparam int S  = WIDTH / STAGES;
    localparam int NG = S / 4;
    localparam int L  = STAGES - 1;

    if (GROUP != 4) begin : g_bad_group
        $error("cla_pipe_adder: GROUP must be 4");
    end
    if (STAGES < 1 || STAGES > WIDTH / 4) begin : g_bad_stages
        $error("cla_pipe_adder: STAGES out of range 1..WIDTH/4");
    end
    if (WIDTH % (4 * STAGES) != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES");
    end

    typedef struct packed {
        logic [3:0] sum;
        logic       pg;
        logic       gg;
        logic       c3;
    } grp_t;

    typedef struct packed {
        logic [S-1:0] sum;
        logic         cout;
        logic         cmsb;
    } slice_t;

    function automatic grp_t cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        grp_t       r;
        p    = x ^ y;
        g    = x & y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        r.sum = p ^ c;
        r.pg  = &p;
        r.gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.c3  = c[3];
        return r;
    endfunction

    // Group lookahead across the slice: C(j+1) = G(j) | P(j)&C(j).
    function automatic slice_t cla_slice(input logic [S-1:0] x, input logic [S-1:0] y,
                                         input logic c_in);
        slice_t r;
        grp_t   g;
        logic   c;
        r = '0;
        c = c_in;
        for (int j = 0; j < NG; j++) begin
            g                  = cla4(x[j*4 +: 4], y[j*4 +: 4], c);
            r.sum[j*4 +: 4]    = g.sum;
            r.cmsb             = g.c3;
            c                  = g.gg | (g.pg & c);
        end
        r.cout = c;
        return r;
    endfunction

    logic [STAGES-1:0] r_v;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_cmsb;

    logic [STAGES:0]   w_en;
    logic [STAGES-1:0] w_v_src;
    logic [STAGES-1:0] w_c_src;
    logic [WIDTH-1:0]  w_a_src   [STAGES];
    logic [WIDTH-1:0]  w_b_src   [STAGES];
    logic [WIDTH-1:0]  w_sum_src [STAGES];
    logic [WIDTH-1:0]  w_sum_nx  [STAGES];
    logic [STAGES-1:0] w_c_nx;
    logic [STAGES-1:0] w_cmsb_nx;
    logic [WIDTH-1:0]  w_sum_out;
    logic              w_ovf;

    // A stage may load when it is empty or the stage after it is moving.
    always_comb begin
        logic [STAGES:0] en_v;
        // NOTE: every combinational output gets a default first so no path infers a latch.
        en_v         = '0;
        en_v[STAGES] = bus.out_ready;
        for (int k = L; k >= 0; k--) begin
            en_v[k] = !r_v[k] | en_v[k+1];
        end
        w_en = en_v;
    end

    // Stage sources: stage 0 takes the ports, later stages take the previous register.
    always_comb begin
        w_v_src      = '0;
        w_c_src      = '0;
        w_a_src[0]   = bus.a;
        w_b_src[0]   = bus.sub ? ~bus.b : bus.b;
        w_sum_src[0] = '0;
        w_v_src[0]   = bus.in_valid;
        w_c_src[0]   = bus.sub | bus.cin;
        for (int k = 1; k < STAGES; k++) begin
            w_a_src[k]   = r_a[k-1];
            w_b_src[k]   = r_b[k-1];
            w_sum_src[k] = r_sum[k-1];
            w_v_src[k]   = r_v[k-1];
            w_c_src[k]   = r_c[k-1];
        end
    end

    always_comb begin
        slice_t sl;
        w_c_nx    = '0;
        w_cmsb_nx = '0;
        for (int k = 0; k < STAGES; k++) begin
            sl                     = cla_slice(w_a_src[k][k*S +: S], w_b_src[k][k*S +: S],
                                               w_c_src[k]);
            w_sum_nx[k]            = w_sum_src[k];
            w_sum_nx[k][k*S +: S]  = sl.sum;
            w_c_nx[k]              = sl.cout;
            w_cmsb_nx[k]           = sl.cmsb;
        end
    end

    // NOTE: only valid bits and the visible result registers are reset; the skew and
    // de-skew datapath is qualified by the valid bits and may hold stale values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v       <= '0;
            r_sum[L]  <= '0;
            r_c[L]    <= 1'b0;
            r_cmsb[L] <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_en[k]) begin
                    // NOTE: state uses non-blocking assignments so every stage samples
                    // the pre-edge value of the stage before it.
                    r_v[k]    <= w_v_src[k];
                    r_a[k]    <= w_a_src[k];
                    r_b[k]    <= w_b_src[k];
                    r_sum[k]  <= w_sum_nx[k];
                    r_c[k]    <= w_c_nx[k];
                    r_cmsb[k] <= w_cmsb_nx[k];
                end
            end
        end
    end

    assign w_ovf = r_c[L] ^ r_cmsb[L];

`ifdef CLA_PIPE_SAT_EN
    // On overflow both operands share a sign, so a's MSB picks the clamp direction.
    always_comb begin
        w_sum_out = r_sum[L];
        if (w_ovf) begin
            w_sum_out = r_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_sum_out = r_sum[L];
`endif

    assign bus.in_ready  = w_en[0];
    assign bus.out_valid = r_v[L];
    assign bus.sum       = w_sum_out;
    assign bus.cout      = r_c[L];
    assign bus.ovf       = w_ovf;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: 32-bit/4-stage and 8-bit/1-stage instances
// checked against an arithmetic reference model with an in-order scoreboard.
module tb_cla_pipe_adder;
    localparam int W  = 32;
    localparam int ST = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   hold;
    exp_t q[$];

    cla_pipe_adder_if #(.WIDTH(W)) bus ();
    cla_pipe_adder_if #(.WIDTH(8)) bus8 ();

    cla_pipe_adder #(.WIDTH(W), .STAGES(ST), .GROUP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cla_pipe_adder #(.WIDTH(8), .STAGES(1), .GROUP(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   t;
        exp_t         e;
        be   = sub ? ~b : b;
        t    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        e.s  = t[W-1:0];
        e.co = t[W];
        e.ov = (a[W-1] == be[W-1]) && (e.s[W-1] != a[W-1]);
`ifdef CLA_PIPE_SAT_EN
        if (e.ov) e.s = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // One cycle: drive at negedge, sample 1ns later, record accepted operands in the model.
    task automatic step(input bit iv, input bit ordy, output bit acc, output bit ovld,
                        output logic [W-1:0] s, output logic co, output logic ov);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        if (iv && !hold) begin
            bus.a   = pick();
            bus.b   = pick();
            bus.cin = 1'($urandom_range(0, 1));
            bus.sub = 1'($urandom_range(0, 1));
        end
        #1;
        acc  = bus.in_valid && bus.in_ready;
        ovld = bus.out_valid;
        s    = bus.sum;
        co   = bus.cout;
        ov   = bus.ovf;
        hold = iv && !acc;
        if (acc) q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    endtask

    task automatic single_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic sub, output logic [W-1:0] s, output logic co,
                             output logic ov, output int lat);
        @(negedge clk);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
        #1;
        s  = bus.sum;
        co = bus.cout;
        ov = bus.ovf;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", bus.sum); end
        n_checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf: got %b%b want 00", bus.cout, bus.ovf); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_checks++; if ({bus8.out_valid, bus8.sum} !== 9'h000) begin n_fail++; $display("FAIL reset_w8: got valid=%b sum=%h want 0/00", bus8.out_valid, bus8.sum); end
    endtask

    task automatic test_carry_ripple();
        logic [W-1:0] s; logic co, ov; int lat;
        single_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, co, ov, lat);
        n_checks++; if (lat !== ST) begin n_fail++; $display("FAIL ripple_latency: got %0d want %0d", lat, ST); end
        n_checks++; if ({s, co, ov} !== {32'h0000_0000, 1'b1, 1'b0}) begin n_fail++; $display("FAIL ripple_result: got sum=%h cout=%b ovf=%b want 00000000/1/0", s, co, ov); end
    endtask

    task automatic test_sub_overflow();
        logic [W-1:0] s, want; logic co, ov; int lat;
`ifdef CLA_PIPE_SAT_EN
        want = 32'h8000_0000;
`else
        want = 32'h7FFF_FFFF;
`endif
        single_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, s, co, ov, lat);
        n_checks++; if (lat !== ST) begin n_fail++; $display("FAIL subovf_latency: got %0d want %0d", lat, ST); end
        n_checks++; if ({s, co, ov} !== {want, 1'b1, 1'b1}) begin n_fail++; $display("FAIL subovf_result: got sum=%h cout=%b ovf=%b want %h/1/1", s, co, ov, want); end
    endtask

    task automatic test_back_to_back();
        bit acc, ovld; logic [W-1:0] s; logic co, ov; exp_t e;
        int sent = 0, got = 0, cyc = 0;
        int first_acc = -1, last_acc = -1, first_take = -1, last_take = -1;
        while ((sent < 100 || got < 100) && cyc < 400) begin
            step(sent < 100, 1'b1, acc, ovld, s, co, ov);
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            if (ovld) begin
                if (first_take < 0) first_take = cyc;
                last_take = cyc;
                got++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: unexpected result sum=%h at cycle %0d", s, cyc);
                end else begin
                    e = q.pop_front();
                    if ({s, co, ov} !== {e.s, e.co, e.ov}) begin
                        n_fail++; $display("FAIL b2b_result #%0d: got %h/%b/%b want %h/%b/%b", got, s, co, ov, e.s, e.co, e.ov);
                    end
                end
            end
            cyc++;
        end
        n_checks++; if (got !== 100) begin n_fail++; $display("FAIL b2b_count: got %0d results want 100", got); end
        n_checks++; if (first_take - first_acc !== ST) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", first_take - first_acc, ST); end
        n_checks++; if (last_take - first_take !== 99) begin n_fail++; $display("FAIL b2b_out_rate: got span %0d want 99", last_take - first_take); end
        n_checks++; if (last_acc - first_acc !== 99) begin n_fail++; $display("FAIL b2b_in_rate: got span %0d want 99", last_acc - first_acc); end
    endtask

    task automatic test_backpressure();
        bit acc, ovld, stalled = 0; logic [W-1:0] s, hs; logic co, ov, hco, hov; exp_t e;
        int accepts = 0, drained = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, acc, ovld, s, co, ov);
            if (acc) accepts++;
            if (ovld && !stalled) begin
                stalled = 1; hs = s; hco = co; hov = ov;
                e = q[0];
                n_checks++; if ({s, co, ov} !== {e.s, e.co, e.ov}) begin n_fail++; $display("FAIL bp_head: got %h/%b/%b want %h/%b/%b", s, co, ov, e.s, e.co, e.ov); end
            end else if (ovld) begin
                n_checks++; if ({s, co, ov} !== {hs, hco, hov}) begin n_fail++; $display("FAIL bp_stable: got %h/%b/%b want %h/%b/%b", s, co, ov, hs, hco, hov); end
            end
        end
        n_checks++; if (accepts !== ST) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", accepts, ST); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, acc, ovld, s, co, ov);
            n_checks++; if ({acc, ovld} !== 2'b11) begin n_fail++; $display("FAIL bp_no_bubble: got accept=%b out_valid=%b want 1/1", acc, ovld); end
            if (ovld && q.size() > 0) begin
                e = q.pop_front();
                n_checks++; if ({s, co, ov} !== {e.s, e.co, e.ov}) begin n_fail++; $display("FAIL bp_pass_result: got %h/%b/%b want %h/%b/%b", s, co, ov, e.s, e.co, e.ov); end
            end
        end
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, acc, ovld, s, co, ov);
            if (ovld) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_duplicate: extra result sum=%h", s);
                end else begin
                    e = q.pop_front();
                    drained++;
                    if ({s, co, ov} !== {e.s, e.co, e.ov}) begin n_fail++; $display("FAIL bp_drain_result: got %h/%b/%b want %h/%b/%b", s, co, ov, e.s, e.co, e.ov); end
                end
            end
        end
        n_checks++; if (drained !== ST || q.size() !== 0) begin n_fail++; $display("FAIL bp_drain_count: got %0d drained, %0d left want %0d/0", drained, q.size(), ST); end
    endtask

    task automatic test_reset_mid_stream();
        bit acc, ovld; logic [W-1:0] s; logic co, ov; int lat; exp_t e;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, acc, ovld, s, co, ov);
        n_checks++; if (q.size() !== 3) begin n_fail++; $display("FAIL rst_inflight: got %0d in flight want 3", q.size()); end
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if ({bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rst_mid_outputs: got valid=%b sum=%h cout=%b ovf=%b want 0", bus.out_valid, bus.sum, bus.cout, bus.ovf); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk) rst = 1'b0;
        q.delete();
        hold = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, acc, ovld, s, co, ov);
            n_checks++; if (ovld !== 1'b0) begin n_fail++; $display("FAIL rst_stale: got out_valid=%b sum=%h want 0", ovld, s); end
        end
        ra = $urandom(); rb = $urandom();
        e = model(ra, rb, 1'b1, 1'b0);
        single_op(ra, rb, 1'b1, 1'b0, s, co, ov, lat);
        n_checks++; if ({lat, s, co, ov} !== {ST, e.s, e.co, e.ov}) begin n_fail++; $display("FAIL rst_recover: got lat=%0d %h/%b/%b want %0d %h/%b/%b", lat, s, co, ov, ST, e.s, e.co, e.ov); end
    endtask

    task automatic test_stages1();
        logic [7:0] want;
`ifdef CLA_PIPE_SAT_EN
        want = 8'h7F;
`else
        want = 8'h80;
`endif
        @(negedge clk);
        bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.sub = 1'b0;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;
        #1;
        n_checks++; if (bus8.in_ready !== 1'b1) begin n_fail++; $display("FAIL s1_in_ready: got %b want 1", bus8.in_ready); end
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if ({bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf} !== {1'b1, want, 1'b0, 1'b1}) begin n_fail++; $display("FAIL s1_result: got valid=%b sum=%h cout=%b ovf=%b want 1/%h/0/1", bus8.out_valid, bus8.sum, bus8.cout, bus8.ovf, want); end
        @(negedge clk);
        #1;
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL s1_single_result: got out_valid=%b want 0", bus8.out_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hold     = 0;
        rst      = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
        bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;

        test_reset();
        test_carry_ripple();
        test_sub_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stream();
        test_stages1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
